// File: rtl/tt_um_ternary_pkg.sv
// -----------------------------------------------------------------------------
// tt_um_ternary_pkg
// Shared definitions for the ternary matmul result path: the transmit FSM
// state encoding, the frame header tag, default geometry of the result vector,
// and a helper that extracts one result from the packed vector and
// sign-extends it to 16 bits.
// -----------------------------------------------------------------------------
package tt_um_ternary_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [3:0] FRAME_TAG     = 4'hC;
  localparam int         DEF_OUT_LEN   = 8;
  localparam int         DEF_ACC_WIDTH = 12;

  // Largest supported vector: 15 results of at most 16 bits each.
  localparam int MAX_OUT_LEN = 15;
  localparam int MAX_VEC_W   = MAX_OUT_LEN * 16;

  // Result r of a packed vector (zero-padded to MAX_VEC_W), sign-extended to
  // 16 bits by replicating bit acc_width-1 into the upper positions.
  function automatic logic [15:0] result_ext(input logic [MAX_VEC_W-1:0] vec,
                                             input int                   acc_width,
                                             input logic [3:0]           r);
    logic [15:0] res;
    logic [7:0]  pos;
    int          base;
    res  = 16'h0000;
    base = int'(r) * acc_width;
    for (int b = 0; b < 16; b++) begin
      if (b < acc_width) begin
        pos = 8'(base + b);
      end else begin
        pos = 8'(base + acc_width - 1);
      end
      res[b] = vec[pos];
    end
    return res;
  endfunction

endpackage

// File: rtl/tt_um_result_stream.sv
// -----------------------------------------------------------------------------
// tt_um_result_stream
// Transmit end of the ternary matmul result path. Captures one vector of
// OUT_LEN signed results in a single handshake and serializes it as a frame:
// one header byte {TAG, seq} followed by every result as sign-extended 16 bits,
// low byte first. Byte stream uses valid/ready flow control.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  result vector handshake (ready only when idle)
//   in_data         packed results, result i at [i*ACC_WIDTH +: ACC_WIDTH]
//   abort           synchronous frame drop, back to idle, seq kept
//   out_data/valid  stream byte and its qualifier (registered)
//   out_ready       sink accepts the byte
//   out_last        final byte of the frame (registered)
//   busy            a frame is in progress
// -----------------------------------------------------------------------------
module tt_um_result_stream
  import tt_um_ternary_pkg::*;
#(
  parameter int         OUT_LEN   = DEF_OUT_LEN,
  parameter int         ACC_WIDTH = DEF_ACC_WIDTH,
  parameter logic [3:0] TAG       = FRAME_TAG
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OUT_LEN*ACC_WIDTH-1:0] in_data,
  input  logic                         abort,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy
);

  localparam int         VEC_W    = OUT_LEN * ACC_WIDTH;
  localparam logic [4:0] LAST_IDX = 5'(2 * OUT_LEN - 1);

  state_t                 state_r, state_nxt_s;
  logic [4:0]             idx_r, idx_nxt_s;
  logic [3:0]             seq_r, seq_nxt_s;
  logic [VEC_W-1:0]       buf_r, buf_nxt_s;
  logic [MAX_VEC_W-1:0]   buf_pad_s;
  logic [15:0]            word_s;
  logic [7:0]             data_r, data_nxt_s;
  logic                   valid_r, valid_nxt_s;
  logic                   last_r, last_nxt_s;

  // Next-state logic: capture, header/data sequencing, abort override.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    seq_nxt_s   = seq_r;
    buf_nxt_s   = buf_r;
    if (abort) begin
      // Abort wins over capture and over a final handshake (seq kept).
      state_nxt_s = ST_IDLE;
      idx_nxt_s   = 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            buf_nxt_s   = in_data;
            state_nxt_s = ST_HDR;
            idx_nxt_s   = 5'd0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_HDR: begin
          if (out_ready) begin
            state_nxt_s = ST_DATA;
            idx_nxt_s   = 5'd0;
          end else begin
            state_nxt_s = ST_HDR;
          end
        end
        ST_DATA: begin
          if (out_ready && (idx_r == LAST_IDX)) begin
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = 5'd0;
            seq_nxt_s   = seq_r + 4'd1;
          end else if (out_ready) begin
            idx_nxt_s = idx_r + 5'd1;
          end else begin
            idx_nxt_s = idx_r;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = 5'd0;
        end
      endcase
    end
  end

  // Output byte for the upcoming cycle, derived from next-state values so the
  // stream outputs can be registered without adding latency.
  always_comb begin
    buf_pad_s              = '0;
    buf_pad_s[VEC_W-1:0]   = buf_nxt_s;
    word_s                 = result_ext(buf_pad_s, ACC_WIDTH, idx_nxt_s[4:1]);
    data_nxt_s             = 8'h00;
    valid_nxt_s            = 1'b0;
    last_nxt_s             = 1'b0;
    case (state_nxt_s)
      ST_HDR: begin
        valid_nxt_s = 1'b1;
        data_nxt_s  = {TAG, seq_nxt_s};
      end
      ST_DATA: begin
        valid_nxt_s = 1'b1;
        data_nxt_s  = idx_nxt_s[0] ? word_s[15:8] : word_s[7:0];
        last_nxt_s  = (idx_nxt_s == LAST_IDX);
      end
      default: begin
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, buffer and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= 5'd0;
      seq_r   <= 4'd0;
      buf_r   <= '0;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      seq_r   <= seq_nxt_s;
      buf_r   <= buf_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign out_last  = last_r;
  assign busy      = (state_r != ST_IDLE);
  // Held low for the whole time reset is asserted.
  assign in_ready  = (state_r == ST_IDLE) && !rst;

endmodule

// File: tb/tb_tt_um_result_stream.sv
// -----------------------------------------------------------------------------
// tb_tt_um_result_stream
// Directed bench for tt_um_result_stream at default geometry (8 x 12-bit).
// Expected frames are built from plain integer arithmetic into a byte queue;
// one compare process checks every valid output cycle against it.
// -----------------------------------------------------------------------------
module tb_tt_um_result_stream;

  localparam int N    = 8;
  localparam int W    = 12;
  localparam int IN_W = N * W;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] in_data = '0;
  logic            abort = 1'b0;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_last;
  logic            busy;

  int    checks = 0;
  int    errors = 0;
  int    model_seq = 0;
  beat_t exp_q[$];

  tt_um_result_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .abort     (abort),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [IN_W-1:0] pack(input int v[N]);
    logic [IN_W-1:0] p;
    logic [31:0]     t;
    p = '0;
    for (int i = 0; i < N; i++) begin
      t = v[i];
      p[i*W +: W] = t[W-1:0];
    end
    return p;
  endfunction

  // Whole expected frame: header, then each result as 16-bit two's complement.
  task automatic push_frame(input int v[N]);
    beat_t       b;
    logic [15:0] w;
    b.d = {4'hC, 4'(model_seq)};
    b.l = 1'b0;
    exp_q.push_back(b);
    for (int i = 0; i < N; i++) begin
      w   = 16'(v[i]);
      b.d = w[7:0];
      b.l = 1'b0;
      exp_q.push_back(b);
      b.d = w[15:8];
      b.l = (i == N - 1);
      exp_q.push_back(b);
    end
    model_seq = (model_seq + 1) % 16;
  endtask

  // Present one vector; returns #1 after the capture edge.
  task automatic send(input int v[N]);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_in_ready_timeout", in_ready, 1);
    push_frame(v);
    in_valid = 1'b1;
    in_data  = pack(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Run out_ready (mode 0: always high, mode 1: 1,0,0 repeating) until the
  // expected queue is empty.
  task automatic drain(input int mode);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 400) begin
      out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b1;
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic rand_vec(output int v[N]);
    for (int i = 0; i < N; i++) begin
      v[i] = int'($urandom_range(0, 4095)) - 2048;
    end
  endtask

  // Compare process: every negedge with out_valid is checked against the model.
  initial begin : compare
    logic       p_valid, p_ready, p_abort, p_last;
    logic [7:0] p_data;
    beat_t      e;
    p_valid = 1'b0; p_ready = 1'b0; p_abort = 1'b0; p_last = 1'b0; p_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_valid = 1'b0;
      end else begin
        chk("busy_vs_valid", busy, out_valid);
        if (p_valid && !p_ready && !p_abort) begin
          chk("stall_valid_held", out_valid, 1);
          chk("stall_data", out_data, p_data);
          chk("stall_last", out_last, p_last);
        end
        if (out_valid) begin
          chk("in_ready_in_frame", in_ready, 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", out_valid, 0);
          end else begin
            e = exp_q[0];
            chk("out_data", out_data, e.d);
            chk("out_last", out_last, e.l);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        p_valid = out_valid; p_ready = out_ready; p_abort = abort;
        p_data  = out_data;  p_last  = out_last;
      end
    end
  end

  initial begin : stim
    int         v1[N];
    int         v2[N];
    logic [7:0] pin1[17];
    int         k;

    pin1 = '{8'hC0, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'hF8,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // Reset values while rst is held.
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    #19 rst = 1'b0;

    // Frame 1: known vector, out_ready high, pinned bytes, no bubbles.
    v1 = '{1, -1, 2047, -2048, 0, 0, 0, 0};
    send(v1);
    chk("model_len", exp_q.size(), 17);
    for (int i = 0; i < 17; i++) begin
      chk("model_pin_byte", exp_q[i].d, pin1[i]);
      chk("model_pin_last", exp_q[i].l, (i == 16));
    end
    chk("latency_hdr", out_data, 8'hC0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk("no_bubble", out_valid, 1);
    end
    @(negedge clk);
    chk("frame_end_valid", out_valid, 0);
    chk("frame1_drained", exp_q.size(), 0);

    // Frame 2: same vector under 1,0,0 backpressure.
    send(v1);
    drain(1);

    // 17 back-to-back frames from reset: headers C0..CF then C0.
    @(posedge clk); #2 rst = 1'b1;
    exp_q.delete();
    model_seq = 0;
    @(negedge clk); #1 rst = 1'b0;
    for (int f = 0; f < 17; f++) begin
      rand_vec(v2);
      send(v2);
      chk("b2b_hdr", out_data, {4'hC, 4'(f % 16)});
      drain(0);
    end

    // Abort while byte 5 is on the bus; next header reuses seq 1.
    rand_vec(v2);
    send(v2);
    repeat (4) @(posedge clk); #1;
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    model_seq = (model_seq + 15) % 16;
    chk("abort_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    send(v2);
    chk("abort_reuse_hdr", out_data, 8'hC1);
    drain(0);

    // Abort on the final handshake: byte consumed, seq not advanced.
    rand_vec(v2);
    send(v2);
    repeat (16) @(posedge clk); #1;
    chk("final_byte_last", out_last, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("final_abort_consumed", exp_q.size(), 0);
    model_seq = (model_seq + 15) % 16;
    chk("final_abort_valid", out_valid, 0);
    send(v2);
    chk("final_abort_hdr", out_data, 8'hC2);
    drain(0);

    // in_valid held high with new data during a frame: second vector waits.
    rand_vec(v1);
    rand_vec(v2);
    @(posedge clk); #1;
    push_frame(v1);
    push_frame(v2);
    in_valid = 1'b1;
    in_data  = pack(v1);
    @(posedge clk); #1;
    in_data = pack(v2);
    chk("hold_busy", busy, 1);
    k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("hold_wait_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain(0);

    // Asynchronous reset in the middle of DATA.
    rand_vec(v2);
    send(v2);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_last", out_last, 0);
    exp_q.delete();
    model_seq = 0;
    @(negedge clk); #1 rst = 1'b0;
    send(v2);
    chk("post_rst_hdr", out_data, 8'hC0);
    drain(0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
